// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection and bubble counting.
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          IFID_valid,
  input  logic [DW-1:0] IFID_pcplus4,
  input  logic [DW-1:0] ID_readdata1,
  input  logic [DW-1:0] ID_readdata2,
  input  logic [DW-1:0] ID_signext,
  input  logic [RW-1:0] IFID_rs,
  input  logic [RW-1:0] IFID_rt,
  input  logic [RW-1:0] IFID_rd,
  input  logic [8:0]    ID_ctrl,
  input  logic          flush,
  input  logic          ex_hold,
  output logic          IDEX_valid_out,
  output logic [DW-1:0] IDEX_pcplus4_out,
  output logic [DW-1:0] IDEX_readdata1_out,
  output logic [DW-1:0] IDEX_readdata2_out,
  output logic [DW-1:0] IDEX_signext_out,
  output logic [RW-1:0] IDEX_rs_out,
  output logic [RW-1:0] IDEX_rt_out,
  output logic [RW-1:0] IDEX_rd_out,
  output logic [8:0]    IDEX_ctrl_out,
  output logic          hazard_stall,
  output logic [CW-1:0] bubble_count
);
  localparam int MEMREAD = 6;
  logic take;
  // rs and rt are both compared even for I-type consumers; a spurious stall is harmless
  assign hazard_stall = IDEX_valid_out & IDEX_ctrl_out[MEMREAD] & IFID_valid & (|IDEX_rt_out) &
                        ((IDEX_rt_out == IFID_rs) | (IDEX_rt_out == IFID_rt));
  assign take = IFID_valid & ~flush & ~hazard_stall;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      IDEX_valid_out     <= 1'b0;
      IDEX_pcplus4_out   <= '0;
      IDEX_readdata1_out <= '0;
      IDEX_readdata2_out <= '0;
      IDEX_signext_out   <= '0;
      IDEX_rs_out        <= '0;
      IDEX_rt_out        <= '0;
      IDEX_rd_out        <= '0;
      IDEX_ctrl_out      <= '0;
      bubble_count       <= '0;
    end else if (!ex_hold) begin
      IDEX_valid_out     <= take;
      IDEX_ctrl_out      <= take ? ID_ctrl : 9'd0;
      IDEX_pcplus4_out   <= IFID_pcplus4;
      IDEX_readdata1_out <= ID_readdata1;
      IDEX_readdata2_out <= ID_readdata2;
      IDEX_signext_out   <= ID_signext;
      IDEX_rs_out        <= IFID_rs;
      IDEX_rt_out        <= IFID_rt;
      IDEX_rd_out        <= IFID_rd;
      if (!flush && hazard_stall && !(&bubble_count)) bubble_count <= bubble_count + 1'b1;
    end
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized scoreboard bench for id_ex_stage against a behavioural pipeline model.
module tb_id_ex_stage;
  localparam logic [8:0] LW  = 9'h1C8;
  localparam logic [8:0] ADD = 9'h106;
  localparam logic [8:0] PT  = 9'h104;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic IFID_valid = 1'b0, flush = 1'b0, ex_hold = 1'b0;
  logic [31:0] IFID_pcplus4 = '0, ID_readdata1 = '0, ID_readdata2 = '0, ID_signext = '0;
  logic [4:0] IFID_rs = '0, IFID_rt = '0, IFID_rd = '0;
  logic [8:0] ID_ctrl = '0;
  logic v1, v2, hz1, hz2;
  logic [31:0] pc1, a1, b1, s1, pc2, a2, b2, s2;
  logic [4:0] rs1, rt1, rd1, rs2, rt2, rd2;
  logic [8:0] c1, c2;
  logic [15:0] cnt1;
  logic [1:0] cnt2;
  int total = 0, bad = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (.clk(clk), .rst_n(rst_n), .IFID_valid(IFID_valid), .IFID_pcplus4(IFID_pcplus4),
    .ID_readdata1(ID_readdata1), .ID_readdata2(ID_readdata2), .ID_signext(ID_signext),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_rd(IFID_rd), .ID_ctrl(ID_ctrl), .flush(flush),
    .ex_hold(ex_hold), .IDEX_valid_out(v1), .IDEX_pcplus4_out(pc1), .IDEX_readdata1_out(a1),
    .IDEX_readdata2_out(b1), .IDEX_signext_out(s1), .IDEX_rs_out(rs1), .IDEX_rt_out(rt1),
    .IDEX_rd_out(rd1), .IDEX_ctrl_out(c1), .hazard_stall(hz1), .bubble_count(cnt1));

  id_ex_stage #(.CW(2)) dut2 (.clk(clk), .rst_n(rst_n), .IFID_valid(IFID_valid), .IFID_pcplus4(IFID_pcplus4),
    .ID_readdata1(ID_readdata1), .ID_readdata2(ID_readdata2), .ID_signext(ID_signext),
    .IFID_rs(IFID_rs), .IFID_rt(IFID_rt), .IFID_rd(IFID_rd), .ID_ctrl(ID_ctrl), .flush(flush),
    .ex_hold(ex_hold), .IDEX_valid_out(v2), .IDEX_pcplus4_out(pc2), .IDEX_readdata1_out(a2),
    .IDEX_readdata2_out(b2), .IDEX_signext_out(s2), .IDEX_rs_out(rs2), .IDEX_rt_out(rt2),
    .IDEX_rd_out(rd2), .IDEX_ctrl_out(c2), .hazard_stall(hz2), .bubble_count(cnt2));

  typedef struct {
    logic v;
    logic [8:0] c;
    logic [31:0] pc, a, b, s;
    logic [4:0] rs, rt, rd;
    int bub;
  } exp_t;

  exp_t q[$];
  exp_t m;
  exp_t e;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", n, act, req);
    end
  endtask

  function automatic int sat(input int x, input int mx);
    return x > mx ? mx : x;
  endfunction

  always @(posedge clk) begin
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("valid", v1, e.v);
      chk("ctrl", c1, e.c);
      chk("count", cnt1, sat(e.bub, 65535));
      chk("count_cw2", cnt2, sat(e.bub, 3));
      chk("valid_cw2", v2, e.v);
      if (e.v) begin
        chk("pcplus4", pc1, e.pc);
        chk("readdata1", a1, e.a);
        chk("readdata2", b1, e.b);
        chk("signext", s1, e.s);
        chk("rs", rs1, e.rs);
        chk("rt", rt1, e.rt);
        chk("rd", rd1, e.rd);
      end
    end
  end

  function automatic exp_t zero_exp();
    exp_t z;
    z.v = 0; z.c = 0; z.pc = 0; z.a = 0; z.b = 0; z.s = 0;
    z.rs = 0; z.rt = 0; z.rd = 0; z.bub = 0;
    return z;
  endfunction

  task automatic step(input logic v, input logic [4:0] rs, rt, rd, input logic [8:0] c,
                      input logic fl, input logic hd);
    logic haz;
    @(negedge clk);
    IFID_valid = v; IFID_rs = rs; IFID_rt = rt; IFID_rd = rd; ID_ctrl = c;
    flush = fl; ex_hold = hd;
    IFID_pcplus4 = $urandom; ID_readdata1 = $urandom; ID_readdata2 = $urandom; ID_signext = $urandom;
    haz = m.v && m.c[6] && v && m.rt != 0 && (m.rt == rs || m.rt == rt);
    #1;
    chk("hazard_stall", hz1, haz);
    chk("hazard_stall_cw2", hz2, haz);
    if (!hd) begin
      if (fl || haz) begin
        m.v = 0; m.c = 0;
        if (!fl) m.bub++;
      end else begin
        m.v = v; m.c = v ? c : 9'd0;
        m.pc = IFID_pcplus4; m.a = ID_readdata1; m.b = ID_readdata2; m.s = ID_signext;
        m.rs = rs; m.rt = rt; m.rd = rd;
      end
    end
    q.push_back(m);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    chk("rst_valid", v1, 0);
    chk("rst_ctrl", c1, 0);
    chk("rst_pcplus4", pc1, 0);
    chk("rst_readdata1", a1, 0);
    chk("rst_rt", rt1, 0);
    chk("rst_count", cnt1, 0);
    chk("rst_count_cw2", cnt2, 0);
    chk("rst_hazard", hz1, 0);
    m = zero_exp();
    IFID_valid = 0; flush = 0; ex_hold = 0;
    repeat (2) begin
      @(negedge clk);
      q.push_back(m);
    end
    @(posedge clk);
    #2;
    rst_n = 1;
  endtask

  initial begin
    m = zero_exp();
    do_reset();
    step(1, 2, 3, 4, PT, 0, 0);
    step(1, 1, 5, 5, LW, 0, 0);
    step(1, 5, 6, 7, ADD, 0, 0);
    step(1, 5, 6, 7, ADD, 0, 0);
    step(1, 0, 0, 0, LW, 0, 0);
    step(1, 0, 9, 10, ADD, 0, 0);
    step(1, 3, 7, 8, LW, 0, 0);
    step(1, 1, 2, 3, ADD, 0, 0);
    step(1, 4, 7, 0, LW, 0, 0);
    step(1, 8, 9, 0, LW, 0, 0);
    step(1, 9, 1, 2, ADD, 0, 0);
    step(1, 9, 1, 2, ADD, 0, 0);
    step(1, 2, 9, 0, LW, 0, 0);
    step(1, 9, 1, 1, ADD, 1, 0);
    step(1, 9, 1, 1, ADD, 1, 0);
    step(1, 3, 11, 0, LW, 0, 0);
    step(1, 11, 2, 2, ADD, 0, 1);
    step(1, 4, 11, 6, ADD, 0, 1);
    step(0, 11, 11, 6, PT, 0, 1);
    step(1, 11, 2, 2, ADD, 0, 0);
    step(1, 11, 2, 2, ADD, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(1, 1, 12, 0, LW, 0, 0);
      step(1, 12, 1, 1, ADD, 0, 0);
      step(1, 12, 1, 1, ADD, 0, 0);
    end
    step(1, 1, 13, 0, LW, 0, 0);
    do_reset();
    step(1, 13, 2, 3, ADD, 0, 0);
    step(0, 1, 2, 3, ADD, 0, 0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(99) < 85, 5'($urandom_range(7)), 5'($urandom_range(7)), 5'($urandom),
           9'($urandom) | ($urandom_range(1) ? 9'h040 : 9'h000),
           $urandom_range(99) < 10, $urandom_range(99) < 15);
    @(posedge clk);
    #2;
    chk("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
